gpio_in_debounce: RTL and testbench
===================================

// Module: gpio_in_debounce
// PURPOSE
// - Input-side GPIO conditioner: consumes raw asynchronous pins (gpio_pin driven by the GPIO UVC driver) and presents clean levels, edge pulses and a sticky interrupt.
// - Synchronises, debounces and edge-detects each pin independently; sits between the pad/UVC interface and the register/interrupt logic.
// PARAMETERS
// - WIDTH            8   number of GPIO pins
// - SYNC_STAGES      2   synchroniser flops per pin (>=2)
// - DEBOUNCE_CYCLES  4   consecutive stable cycles required to accept a new level (>=1)
// PORTS
// - clk_i      in   1      single clock; every flop is in this domain
// - rst_i      in   1      asynchronous, active-high reset
// - gpio_i     in   WIDTH  raw pin levels, asynchronous to clk_i
// - rise_en_i  in   WIDTH  per-pin enable: rising edge sets status
// - fall_en_i  in   WIDTH  per-pin enable: falling edge sets status
// - clr_i      in   WIDTH  per-pin status clear, one-cycle pulse (W1C)
// - gpio_o     out  WIDTH  debounced level
// - rise_o     out  WIDTH  one-cycle pulse on accepted 0->1
// - fall_o     out  WIDTH  one-cycle pulse on accepted 1->0
// - status_o   out  WIDTH  sticky edge status
// - irq_o      out  1      interrupt request
// BEHAVIOUR
// - Reset (async assert, sync release): sync flops, gpio_o, counters, rise_o, fall_o, status_o = 0; irq_o = 0.
// - Sync: gpio_i -> SYNC_STAGES-flop chain per pin; sync_q is the last stage.
// - Debounce, per pin, counter width $clog2(DEBOUNCE_CYCLES+1):
//   - sync_q == gpio_o: counter <= 0.
//   - sync_q != gpio_o and counter == DEBOUNCE_CYCLES-1: gpio_o <= sync_q, counter <= 0, matching edge pulse registered in the same edge.
//   - otherwise counter <= counter+1.
//   - Glitch shorter than DEBOUNCE_CYCLES cycles at sync_q: no gpio_o change, no pulse.
// - Latency: a gpio_i step held stable reaches gpio_o, rise_o/fall_o exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first sampling clk_i edge.
// - rise_o/fall_o: registered, high exactly one cycle, never both for one pin in the same cycle.
// - Status, per pin: set = (rise_o & rise_en_i) | (fall_o & fall_en_i), evaluated on the cycle the pulse is high; set takes priority over clr_i in the same cycle; clr_i alone clears; otherwise hold.
// - Enables are sampled with the pulse; disabling an enable does not clear existing status.
// - irq_o: registered, = |(effective status) of the next state, so it tracks status_o with no extra cycle.
// - Pin held high through reset: gpio_o = 0 after reset, then one rise_o after the normal latency.
// - Reset mid-debounce: counter discarded, no pulse produced from the pre-reset transition.
// - Pins fully independent; no cross-pin arbitration.
// CONFIGURATION
// - GPIO_IN_IRQ_MASK_EN defined: adds port irq_mask_i in WIDTH; irq_o = |(status_next & ~irq_mask_i), registered; status_o is still set regardless of mask.
// - Not defined: no irq_mask_i port; irq_o = |status_next.
// TESTING
// - Reset with gpio_i=8'h00, then gpio_i[0] 0->1 held: gpio_o[0]=1 and rise_o[0] 1-cycle pulse exactly 6 cycles later (2+4).
// - gpio_i[3] high for 3 cycles then low: no gpio_o, rise_o or fall_o change on any pin.
// - rise_en_i=8'h01, gpio_i[0] rises: status_o=8'h01, irq_o=1; clr_i=8'h01 pulse -> status_o=0, irq_o=0 next cycle.
// - clr_i[0] pulsed in the same cycle as rise_o[0] with rise_en_i[0]=1: status_o[0] stays 1.
// - fall_en_i=8'h80, rise_en_i=0, gpio_i[7] toggles 0->1->0 (each held 10 cycles): only the fall sets status_o[7]; rise_o[7] still pulses.
// - GPIO_IN_IRQ_MASK_EN: irq_mask_i=8'h02, pin 1 rise enabled: status_o[1]=1, irq_o=0; drop mask -> irq_o=1 next cycle.
// - rst_i asserted 2 cycles after gpio_i[2] rises: all outputs 0 immediately; after release with gpio_i[2] still high, one rise_o[2] after full latency.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// ---------------------------------------------------------------------------
// gpio_in_debounce
//
// Input-side GPIO conditioner. Each raw pin is synchronised into clk_i,
// debounced (a new level must hold for DEBOUNCE_CYCLES consecutive cycles
// before it is accepted), and edge-detected. Accepted edges can set a sticky
// per-pin status bit, and the OR of the status drives an interrupt request.
// All pins are handled independently.
//
// Ports:
//   clk_i       single clock, every flop lives in this domain
//   rst_i       asynchronous, active-high reset
//   gpio_i      raw pin levels, asynchronous to clk_i
//   rise_en_i   per-pin: an accepted rising edge sets status
//   fall_en_i   per-pin: an accepted falling edge sets status
//   clr_i       per-pin write-1-to-clear status pulse
//   irq_mask_i  per-pin interrupt mask (only with GPIO_IN_IRQ_MASK_EN)
//   gpio_o      debounced level
//   rise_o      one-cycle pulse on an accepted 0->1
//   fall_o      one-cycle pulse on an accepted 1->0
//   status_o    sticky edge status
//   irq_o       interrupt request, registered, tracks status_o directly
//
// Build option:
//   GPIO_IN_IRQ_MASK_EN  when defined, adds irq_mask_i; masked pins still
//                        set status_o but do not raise irq_o.
// ---------------------------------------------------------------------------
module gpio_in_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] gpio_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] clr_i,
`ifdef GPIO_IN_IRQ_MASK_EN
    input  logic [WIDTH-1:0] irq_mask_i,
`endif
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] status_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] status_set;
    logic [WIDTH-1:0] irq_src;

    // Synchroniser chain: stage 0 samples the raw pin, the last stage feeds
    // the debouncer.
    always_comb begin
        sync_d[0] = gpio_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Debounce: the counter runs while the synchronised level disagrees with
    // the accepted level and restarts whenever they agree again, so any
    // disagreement shorter than DEBOUNCE_CYCLES never reaches gpio_o.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int p = 0; p < WIDTH; p++) begin
            cnt_d[p] = cnt_q[p];
            if (sync_last[p] == level_q[p]) begin
                cnt_d[p] = '0;
            end else if (cnt_q[p] == CNT_MAX) begin
                level_d[p] = sync_last[p];
                cnt_d[p]   = '0;
                rise_d[p]  = sync_last[p];
                fall_d[p]  = ~sync_last[p];
            end else begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end
        end
    end

    // Status: a new edge wins over a clear arriving in the same cycle so that
    // an event is never lost to a concurrent acknowledge.
    always_comb begin
        status_set = (rise_q & rise_en_i) | (fall_q & fall_en_i);
        status_d   = (status_q & ~clr_i) | status_set;
`ifdef GPIO_IN_IRQ_MASK_EN
        irq_src    = status_d & ~irq_mask_i;
`else
        irq_src    = status_d;
`endif
        // Built from the next status so irq_o changes together with status_o.
        irq_d      = |irq_src;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int p = 0; p < WIDTH; p++) begin
                cnt_q[p] <= '0;
            end
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int p = 0; p < WIDTH; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign gpio_o   = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_debounce
//
// Directed bench for gpio_in_debounce (WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). A table of {inputs, hold cycles, expected outputs}
// records is applied in order; hand-written sequences cover glitch
// rejection, the optional irq mask (GPIO_IN_IRQ_MASK_EN) and reset in the
// middle of a debounce.
// ---------------------------------------------------------------------------
module tb_gpio_in_debounce;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] gpio_i;
    logic [7:0] rise_en_i;
    logic [7:0] fall_en_i;
    logic [7:0] clr_i;
`ifdef GPIO_IN_IRQ_MASK_EN
    logic [7:0] irq_mask_i;
`endif
    logic [7:0] gpio_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] status_o;
    logic       irq_o;

    gpio_in_debounce #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .gpio_i    (gpio_i),
        .rise_en_i (rise_en_i),
        .fall_en_i (fall_en_i),
        .clr_i     (clr_i),
`ifdef GPIO_IN_IRQ_MASK_EN
        .irq_mask_i(irq_mask_i),
`endif
        .gpio_o    (gpio_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .status_o  (status_o),
        .irq_o     (irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [7:0] gpio;
        logic [7:0] rise_en;
        logic [7:0] fall_en;
        logic [7:0] clr;
        int         hold;
        logic [7:0] exp_gpio;
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
        logic [7:0] exp_status;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic [7:0] g, input logic [7:0] re, input logic [7:0] fe,
                       input logic [7:0] c, input int h, input logic [7:0] eg,
                       input logic [7:0] er, input logic [7:0] ef,
                       input logic [7:0] es, input logic ei);
        vec_t v;
        v.gpio = g; v.rise_en = re; v.fall_en = fe; v.clr = c; v.hold = h;
        v.exp_gpio = eg; v.exp_rise = er; v.exp_fall = ef;
        v.exp_status = es; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    // Clear is a pulse: it is only present for the first edge of a record.
    task automatic apply(input vec_t v, input int idx);
        gpio_i    = v.gpio;
        rise_en_i = v.rise_en;
        fall_en_i = v.fall_en;
        clr_i     = v.clr;
        repeat (v.hold) begin
            @(posedge clk_i); #1;
            clr_i = '0;
        end
        check($sformatf("row%0d gpio_o", idx),   gpio_o,   v.exp_gpio);
        check($sformatf("row%0d rise_o", idx),   rise_o,   v.exp_rise);
        check($sformatf("row%0d fall_o", idx),   fall_o,   v.exp_fall);
        check($sformatf("row%0d status_o", idx), status_o, v.exp_status);
        check($sformatf("row%0d irq_o", idx),    {7'd0, irq_o}, {7'd0, v.exp_irq});
    endtask

    logic [7:0] g_now;

    initial begin
        rst_i     = 1'b1;
        gpio_i    = '0;
        rise_en_i = '0;
        fall_en_i = '0;
        clr_i     = '0;
`ifdef GPIO_IN_IRQ_MASK_EN
        irq_mask_i = '0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        check("reset gpio_o",   gpio_o,   8'h00);
        check("reset rise_o",   rise_o,   8'h00);
        check("reset fall_o",   fall_o,   8'h00);
        check("reset status_o", status_o, 8'h00);
        check("reset irq_o",    {7'd0, irq_o}, 8'h00);
        rst_i = 1'b0;

        //   gpio   rise  fall  clr  hold gpio_o rise  fall  stat  irq
        add(8'h01, 8'h01, 8'h00, 8'h00, 5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0); // one cycle before acceptance
        add(8'h01, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0); // accepted at 2+4
        add(8'h01, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1); // pulse gone, status set
        add(8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0); // W1C
        add(8'h00, 8'h01, 8'h00, 8'h00, 6, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0); // fall, not enabled
        add(8'h01, 8'h01, 8'h00, 8'h00, 6, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0); // rise again
        add(8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1); // set beats clear
        add(8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0); // clear alone
        add(8'h81, 8'h00, 8'h80, 8'h00, 6, 8'h81, 8'h80, 8'h00, 8'h00, 1'b0); // pin7 rise, not enabled
        add(8'h81, 8'h00, 8'h80, 8'h00, 4, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0); // held 10 cycles
        add(8'h01, 8'h00, 8'h80, 8'h00, 6, 8'h01, 8'h00, 8'h80, 8'h00, 1'b0); // pin7 fall
        add(8'h01, 8'h00, 8'h80, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h80, 1'b1); // fall sets status
        add(8'h01, 8'h00, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h80, 1'b1); // disabling keeps status
        add(8'h01, 8'h00, 8'h00, 8'h80, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h31, 8'hff, 8'h00, 8'h00, 6, 8'h31, 8'h30, 8'h00, 8'h00, 1'b0); // two pins together
        add(8'h31, 8'hff, 8'h00, 8'h00, 1, 8'h31, 8'h00, 8'h00, 8'h30, 1'b1);
        add(8'h31, 8'hff, 8'h00, 8'h10, 1, 8'h31, 8'h00, 8'h00, 8'h20, 1'b1); // per-pin clear
        add(8'h31, 8'hff, 8'h00, 8'h20, 1, 8'h31, 8'h00, 8'h00, 8'h00, 1'b0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Pin 3 high for only 3 cycles: nothing may move on any pin.
        gpio_i = 8'h39;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk_i); #1;
            if (i == 2) gpio_i = 8'h31;
            check($sformatf("glitch c%0d gpio_o", i), gpio_o, 8'h31);
            check($sformatf("glitch c%0d edges", i), rise_o | fall_o, 8'h00);
        end
        g_now = 8'h31;

`ifdef GPIO_IN_IRQ_MASK_EN
        // Masked pin 1 sets status but holds irq low until the mask drops.
        irq_mask_i = 8'h02;
        gpio_i     = 8'h33;
        repeat (7) begin @(posedge clk_i); #1; end
        check("mask status_o", status_o, 8'h02);
        check("mask irq_o",    {7'd0, irq_o}, 8'h00);
        irq_mask_i = 8'h00;
        @(posedge clk_i); #1;
        check("unmask irq_o",  {7'd0, irq_o}, 8'h01);
        clr_i = 8'h02;
        @(posedge clk_i); #1;
        clr_i = 8'h00;
        check("mask clr status_o", status_o, 8'h00);
        g_now = 8'h33;
`endif

        // Pin 2 rises, reset lands mid-debounce; pins already high are
        // dropped to 0 by reset and re-accepted after the full latency.
        g_now  = g_now | 8'h04;
        gpio_i = g_now;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        #1;
        check("async rst gpio_o",   gpio_o,   8'h00);
        check("async rst rise_o",   rise_o,   8'h00);
        check("async rst status_o", status_o, 8'h00);
        check("async rst irq_o",    {7'd0, irq_o}, 8'h00);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk_i); #1;
            check($sformatf("post rst c%0d rise_o", i), rise_o, (i == 6) ? g_now : 8'h00);
            check($sformatf("post rst c%0d gpio_o", i), gpio_o, (i >= 6) ? g_now : 8'h00);
            check($sformatf("post rst c%0d fall_o", i), fall_o, 8'h00);
            check($sformatf("post rst c%0d status_o", i), status_o, (i >= 7) ? g_now : 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
